// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction sequencer (cart, payment, change, display mode)
// Optional VEND_CTRL_DISCOUNT_EN: 12.5% off carts of 10+ items on entry to PAY.
module vend_ctrl #(
  parameter int PAY_TIMEOUT = 1000,
  parameter int HOLD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] price,
  input  logic [3:0] num,
  input  logic       btn_add,
  input  logic       btn_pay,
  input  logic       btn_cancel,
  input  logic       coin_valid,
  input  logic [3:0] coin_amt,
  output logic [7:0] cur_unit_price,
  output logic [3:0] total_num,
  output logic [7:0] total_price,
  output logic [7:0] paid,
  output logic [7:0] change,
  output logic [1:0] disp_mode,
  output logic       dispense,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, SHOP, PAY, CHANGE, DONE} state_t;
  state_t state;
  logic [3:0] price_q, num_q;
  logic [15:0] cnt;
  logic refund;
  logic [7:0] prod, paid_new, refund_amt, pay_price;
  logic [4:0] num_sum;
  logic [8:0] price_sum, coin_sum;
  logic add_ok, timeout;
  always_comb begin
    prod = {4'd0, price} * {4'd0, num};
    num_sum = {1'b0, total_num} + {1'b0, num};
    price_sum = {1'b0, total_price} + {1'b0, prod};
    add_ok = num != 4'd0 && price != 4'd0 && num_sum <= 5'd15 && !price_sum[8];
    coin_sum = {1'b0, paid} + {5'd0, coin_amt};
    paid_new = coin_sum[8] ? 8'hff : coin_sum[7:0];
    refund_amt = coin_valid ? paid_new : paid;
    timeout = cnt == 16'(PAY_TIMEOUT - 1);
`ifdef VEND_CTRL_DISCOUNT_EN
    pay_price = total_num >= 4'd10 ? total_price - {3'd0, total_price[7:3]} : total_price;
`else
    pay_price = total_price;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      price_q <= '0;
      num_q <= '0;
      cnt <= '0;
      refund <= 1'b0;
      cur_unit_price <= '0;
      total_num <= '0;
      total_price <= '0;
      paid <= '0;
      change <= '0;
      disp_mode <= '0;
      dispense <= 1'b0;
      err <= 1'b0;
    end else begin
      cur_unit_price <= prod;
      price_q <= price;
      num_q <= num;
      dispense <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE, SHOP: begin
          if (price != price_q || num != num_q) disp_mode <= 2'd0;
          if (btn_cancel) begin
            if (state == SHOP) begin
              state <= IDLE;
              total_num <= '0;
              total_price <= '0;
              disp_mode <= 2'd0;
            end
          end else if (coin_valid) err <= 1'b1;
          else if (btn_pay) begin
            if (state == SHOP) begin
              state <= PAY;
              paid <= '0;
              cnt <= '0;
              disp_mode <= 2'd2;
              total_price <= pay_price;
            end else err <= 1'b1;
          end else if (btn_add) begin
            if (add_ok) begin
              total_num <= num_sum[3:0];
              total_price <= price_sum[7:0];
              disp_mode <= 2'd1;
              state <= SHOP;
            end else err <= 1'b1;
          end
        end
        PAY: begin
          // a cancel, or a timeout with no coin this cycle, refunds everything inserted
          if (btn_cancel || (!coin_valid && timeout)) begin
            state <= CHANGE;
            change <= refund_amt;
            total_num <= '0;
            total_price <= '0;
            refund <= 1'b1;
          end else if (coin_valid) begin
            paid <= paid_new;
            cnt <= '0;
            if (paid_new >= total_price) begin
              change <= paid_new - total_price;
              refund <= 1'b0;
              state <= CHANGE;
            end
          end else cnt <= cnt + 16'd1;
        end
        CHANGE: begin
          err <= coin_valid;
          dispense <= !refund;
          disp_mode <= 2'd3;
          cnt <= '0;
          state <= DONE;
        end
        DONE: begin
          err <= coin_valid;
          if (cnt == 16'(HOLD_CYCLES - 1)) begin
            state <= IDLE;
            total_num <= '0;
            total_price <= '0;
            paid <= '0;
            change <= '0;
            disp_mode <= 2'd0;
            refund <= 1'b0;
          end else cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
